// File: rtl/im_loader.sv
// Program loader: length-prefixed big-endian byte stream -> 32-bit instruction memory words.
// Define IM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the payload.
module im_loader #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_ld,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic          ld_in_valid,
    input  logic [7:0]    ld_in_byte,
    output logic          ld_in_ready,
    output logic          im_wr_en,
    output logic [AW-1:0] im_wr_addr,
    output logic [31:0]   im_wr_data,
    output logic          cpu_hold,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          ld_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef IM_LOADER_CSUM_EN
    localparam logic [2:0] ST_CSUM   = 3'd4;
`endif
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [16:0] MAX_LEN = 17'(WORDS);

    logic [2:0]    state;
    logic [AW-1:0] ptr;
    logic [15:0]   wcnt;
    logic [15:0]   len;
    logic [7:0]    len_hi;
    logic [1:0]    phase;
    logic [23:0]   shift;
`ifdef IM_LOADER_CSUM_EN
    logic [7:0]    csum;
`endif

    logic [15:0] len_next;
    logic        len_bad;

    assign len_next = {len_hi, ld_in_byte};
    assign len_bad  = (len_next == 16'd0) || ({1'b0, len_next} > MAX_LEN);

    // Every state between IDLE and DONE consumes the byte stream.
    assign ld_in_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA)
`ifdef IM_LOADER_CSUM_EN
                      || (state == ST_CSUM)
`endif
                      ;
    assign ld_busy  = (state != ST_IDLE);
    assign cpu_hold = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_ld) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register here samples the pre-edge values of all the others.
            state      <= ST_IDLE;
            ptr        <= '0;
            wcnt       <= '0;
            len        <= '0;
            len_hi     <= '0;
            phase      <= '0;
            shift      <= '0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            ld_done    <= 1'b0;
            ld_err     <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            im_wr_en <= 1'b0;
            ld_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ld_start) begin
                        ptr    <= ld_base;
                        wcnt   <= '0;
                        phase  <= '0;
                        ld_err <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
                        csum   <= '0;
`endif
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (ld_in_valid) begin
                        len_hi <= ld_in_byte;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (ld_in_valid) begin
                        if (len_bad) begin
                            ld_err <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            len   <= len_next;
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (ld_in_valid) begin
                        phase <= phase + 2'd1;
`ifdef IM_LOADER_CSUM_EN
                        csum  <= csum ^ ld_in_byte;
`endif
                        if (phase == 2'd3) begin
                            im_wr_en   <= 1'b1;
                            im_wr_addr <= ptr;
                            im_wr_data <= {shift, ld_in_byte};
                            ptr        <= ptr + AW'(1);
                            wcnt       <= wcnt + 16'd1;
                            if (wcnt == len - 16'd1) begin
`ifdef IM_LOADER_CSUM_EN
                                state <= ST_CSUM;
`else
                                state <= ST_DONE;
`endif
                            end
                        end else begin
                            shift <= {shift[15:0], ld_in_byte};
                        end
                    end
                end
`ifdef IM_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (ld_in_valid) begin
                        if (ld_in_byte != csum) ld_err  <= 1'b1;
                        else                    ld_done <= 1'b1;
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
`ifndef IM_LOADER_CSUM_EN
                    // Pulse lands one cycle after the final write strobe.
                    ld_done <= !ld_err;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: expected IM writes are queued as stimulus is
// driven and compared by a monitor as the write strobes appear.
module tb_im_loader;

    localparam int WORDS = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst_ld;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic          ld_in_valid;
    logic [7:0]    ld_in_byte;
    logic          ld_in_ready;
    logic          im_wr_en;
    logic [AW-1:0] im_wr_addr;
    logic [31:0]   im_wr_data;
    logic          cpu_hold;
    logic          ld_busy;
    logic          ld_done;
    logic          ld_err;

    im_loader #(.WORDS(WORDS), .AW(AW)) dut (
        .clk(clk), .rst_ld(rst_ld), .ld_start(ld_start), .ld_base(ld_base),
        .ld_in_valid(ld_in_valid), .ld_in_byte(ld_in_byte), .ld_in_ready(ld_in_ready),
        .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
        .cpu_hold(cpu_hold), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] payload_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;
    int last_wr_cyc = -100;
    int prev_wr_cyc = -100;
    int done_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_ld && im_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", im_wr_addr, im_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({im_wr_addr, im_wr_data} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             im_wr_addr, im_wr_data, e.addr, e.data);
                end
            end
            wr_cnt++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
        end
        if (ld_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ld_done && im_wr_en) overlap_cnt++;
    end

    // All stimulus tasks are entered and left 1 time unit after a rising edge.
    task automatic start(input logic [AW-1:0] base);
        ld_base  = base;
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        ld_in_valid = 1'b1;
        ld_in_byte  = b;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = ld_in_ready;
            @(posedge clk); #1;
            n++;
        end
        ld_in_valid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL byte_timeout: byte %h not accepted within 64 cycles, required acceptance", b);
        end
    endtask

    // Length prefix, payload from payload_q, and the checksum byte when enabled.
    task automatic body(input logic [AW-1:0] base, input logic [15:0] n, input int gap, input bit bad_csum);
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (n != 16'd0 && int'(n) <= WORDS) begin
            for (int i = 0; i < int'(n); i++) begin
                w = payload_q[i];
                exp_q.push_back('{addr: base + AW'(i), data: w});
                for (int k = 3; k >= 0; k--) begin
                    send_byte(w[8*k +: 8], gap);
                    x ^= w[8*k +: 8];
                end
            end
`ifdef IM_LOADER_CSUM_EN
            send_byte(bad_csum ? (x ^ 8'h01) : x, gap);
`else
            if (bad_csum) x = 8'h00;
`endif
        end
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        int base_cnt = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clk); #1;
            if (done_cnt != base_cnt) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_ld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({ld_in_ready, im_wr_en, cpu_hold, ld_busy, ld_done, ld_err} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b, required 000000",
                               {ld_in_ready, im_wr_en, cpu_hold, ld_busy, ld_done, ld_err}); end
        checks++; if ({im_wr_addr, im_wr_data} !== 40'h0) begin
            errors++; $display("FAIL reset_wr_bus: got addr=%0d data=%h, required 0/0", im_wr_addr, im_wr_data); end
        rst_ld = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit seen;
        start(8'd0);
        checks++; if ({cpu_hold, ld_busy, ld_in_ready} !== 3'b111) begin
            errors++; $display("FAIL start_flags: got hold/busy/ready=%b, required 111", {cpu_hold, ld_busy, ld_in_ready}); end
        payload_q = '{32'h2008_0005, 32'h0800_0C00};
        body(8'd0, 16'd2, 0, 1'b0);
        checks++; if (cpu_hold !== 1'b1) begin
            errors++; $display("FAIL hold_during_load: got %b, required 1", cpu_hold); end
        wait_done(20, seen);
        checks++; if (!seen) begin
            errors++; $display("FAIL basic_done: ld_done got no pulse, required one"); end
        checks++; if (done_cyc !== last_wr_cyc + 1) begin
            errors++; $display("FAIL done_timing: got cycle %0d, required %0d", done_cyc, last_wr_cyc + 1); end
        checks++; if (last_wr_cyc - prev_wr_cyc !== 4) begin
            errors++; $display("FAIL write_spacing: got %0d cycles, required 4", last_wr_cyc - prev_wr_cyc); end
        checks++; if ({cpu_hold, ld_busy} !== 2'b00) begin
            errors++; $display("FAIL hold_after_done: got hold/busy=%b, required 00", {cpu_hold, ld_busy}); end
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL basic_missing: got %0d writes outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        bit seen;
        int w0 = wr_cnt;
        payload_q = '{32'hAAAA_AAAA, 32'hBBBB_BBBB};
        start(8'd255);
        body(8'd255, 16'd2, 0, 1'b0);
        wait_done(20, seen);
        checks++; if (!seen || wr_cnt - w0 != 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL wrap: got done=%b writes=%0d pending=%0d, required 1/2/0", seen, wr_cnt - w0, exp_q.size()); end
    endtask

    task automatic test_bad_length;
        bit seen;
        int w0 = wr_cnt;
        int d0 = done_cnt;
        logic [15:0] lens [2] = '{16'h0000, 16'h0101};
        for (int i = 0; i < 2; i++) begin
            payload_q.delete();
            start(8'd3);
            body(8'd3, lens[i], 0, 1'b0);
            checks++; if ({ld_err, ld_busy, ld_in_ready, cpu_hold} !== 4'b1000) begin
                errors++; $display("FAIL bad_len_%h: got err/busy/ready/hold=%b, required 1000",
                                   lens[i], {ld_err, ld_busy, ld_in_ready, cpu_hold}); end
            wait_done(8, seen);
        end
        checks++; if (wr_cnt != w0 || done_cnt != d0) begin
            errors++; $display("FAIL bad_len_side_effects: got writes=%0d dones=%0d, required 0/0", wr_cnt - w0, done_cnt - d0); end
    endtask

    task automatic test_full_depth;
        bit seen;
        int w0 = wr_cnt;
        payload_q.delete();
        for (int i = 0; i < WORDS; i++) payload_q.push_back({8'(i), ~8'(i), 8'h5A, 8'(i * 3)});
        start(8'd10);
        checks++; if (ld_err !== 1'b0) begin
            errors++; $display("FAIL err_clear_on_start: got %b, required 0", ld_err); end
        body(8'd10, 16'd256, 0, 1'b0);
        wait_done(20, seen);
        checks++; if (!seen || wr_cnt - w0 != WORDS || exp_q.size() != 0 || ld_err !== 1'b0) begin
            errors++; $display("FAIL full_depth: got done=%b writes=%0d pending=%0d err=%b, required 1/256/0/0",
                               seen, wr_cnt - w0, exp_q.size(), ld_err); end
    endtask

    task automatic test_stall_and_ignored_start;
        bit seen;
        int w0 = wr_cnt;
        start(8'd5);
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        exp_q.push_back('{addr: 8'd5, data: 32'h1234_5678});
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        ld_base  = 8'd99;
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        checks++; if ({ld_busy, ld_in_ready, ld_err} !== 3'b110) begin
            errors++; $display("FAIL ignored_start: got busy/ready/err=%b, required 110", {ld_busy, ld_in_ready, ld_err}); end
        send_byte(8'h56, 1);
        send_byte(8'h78, 1);
`ifdef IM_LOADER_CSUM_EN
        send_byte(8'h08, 1);
`endif
        wait_done(20, seen);
        checks++; if (!seen || wr_cnt - w0 != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL stalled_load: got done=%b writes=%0d pending=%0d, required 1/1/0", seen, wr_cnt - w0, exp_q.size()); end
    endtask

    task automatic test_reset_mid_load;
        bit seen;
        int w0;
        start(8'd20);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        rst_ld = 1'b0;
        @(posedge clk); #1;
        checks++; if ({ld_in_ready, im_wr_en, cpu_hold, ld_busy, ld_done, ld_err} !== 6'b0) begin
            errors++; $display("FAIL midload_reset_flags: got %b, required 000000",
                               {ld_in_ready, im_wr_en, cpu_hold, ld_busy, ld_done, ld_err}); end
        checks++; if ({im_wr_addr, im_wr_data} !== 40'h0) begin
            errors++; $display("FAIL midload_reset_bus: got addr=%0d data=%h, required 0/0", im_wr_addr, im_wr_data); end
        rst_ld = 1'b1;
        @(posedge clk); #1;
        w0 = wr_cnt;
        payload_q = '{32'hCAFE_BABE};
        start(8'd20);
        body(8'd20, 16'd1, 0, 1'b0);
        wait_done(20, seen);
        checks++; if (!seen || wr_cnt - w0 != 1 || exp_q.size() != 0) begin
            errors++; $display("FAIL reload_after_reset: got done=%b writes=%0d pending=%0d, required 1/1/0", seen, wr_cnt - w0, exp_q.size()); end
    endtask

`ifdef IM_LOADER_CSUM_EN
    task automatic test_csum;
        bit seen;
        payload_q = '{32'h0102_0304};
        start(8'd40);
        body(8'd40, 16'd1, 0, 1'b0);
        wait_done(20, seen);
        checks++; if (!seen || ld_err !== 1'b0) begin
            errors++; $display("FAIL csum_good: got done=%b err=%b, required 1/0", seen, ld_err); end
        start(8'd40);
        body(8'd40, 16'd1, 0, 1'b1);
        wait_done(8, seen);
        checks++; if (seen || ld_err !== 1'b1 || cpu_hold !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL csum_bad: got done=%b err=%b hold=%b pending=%0d, required 0/1/0/0",
                               seen, ld_err, cpu_hold, exp_q.size()); end
    endtask
`endif

    initial begin
        rst_ld      = 1'b0;
        ld_start    = 1'b0;
        ld_base     = '0;
        ld_in_valid = 1'b0;
        ld_in_byte  = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_bad_length();
        test_full_depth();
        test_stall_and_ignored_start();
        test_reset_mid_load();
`ifdef IM_LOADER_CSUM_EN
        test_csum();
`endif
        checks++; if (overlap_cnt != 0) begin
            errors++; $display("FAIL done_write_overlap: got %0d overlapping cycles, required 0", overlap_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/im_loader.md
# im_loader

Program loader for the 1 KB instruction memory. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake and assembles it into 32-bit words. Each word is written through the instruction memory's word write port. While loading, it holds the processor's PC/IM in reset, so fetch restarts cleanly at 0x0000_3000 once the image is in place.

## Interface
Parameters:
- WORDS, 256: instruction memory depth in words (1 KB / 4).
- AW, 8: word address width, log2(WORDS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_ld  in  1  reset; synchronous, active-low.
- ld_start  in  1  one-cycle load request; honoured only in IDLE.
- ld_base  in  AW  first word index written, sampled on accepted ld_start.
- ld_in_valid  in  1  byte stream valid.
- ld_in_byte  in  8  byte stream data.
- ld_in_ready  out  1  byte accepted on a cycle where valid && ready.
- im_wr_en  out  1  one-cycle word write strobe to IM.
- im_wr_addr  out  AW  word index for the write.
- im_wr_data  out  32  word data; first received byte in [31:24].
- cpu_hold  out  1  high from accepted ld_start until DONE exits; drives rst_pc/rst_im.
- ld_busy  out  1  high in every state except IDLE.
- ld_done  out  1  one-cycle pulse, load finished without error.
- ld_err  out  1  sticky error flag; cleared on next accepted ld_start or reset.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM (only when macro is defined), DONE.
- IDLE
  - ld_in_ready=0.
  - ld_start=1: latch ld_base into the write pointer, clear the word counter, byte phase and ld_err, then go to LEN_HI.
- LEN_HI / LEN_LO
  - Accept two bytes forming a 16-bit word count N, high byte first.
  - N==0 or N>WORDS: set ld_err and go to IDLE. No writes occur.
- DATA
  - Accept bytes into a 32-bit shift register, MSB first, with a 2-bit byte phase.
  - On the 4th byte, register the write: im_wr_en=1, im_wr_addr=pointer, im_wr_data=assembled word.
  - After each write, the pointer increments modulo WORDS (wraps 255→0) and the word count increments.
  - After the Nth word: go to CSUM if the macro is defined, otherwise DONE.
- DONE
  - ld_done=1 for one cycle, unless ld_err is set.
  - Return to IDLE the next cycle; cpu_hold drops on that transition.
- ld_in_ready=1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE and DONE.
- ld_start outside IDLE is ignored.
- Stalls on ld_in_valid may last any number of cycles; state and partial word are held.
- Reset mid-load:
  - Return to IDLE; cpu_hold, ld_busy, im_wr_en and ld_err go to 0.
  - Words already written remain in IM.

## Timing
- Reset values: ld_in_ready=0, im_wr_en=0, im_wr_addr=0, im_wr_data=0, cpu_hold=0, ld_busy=0, ld_done=0, ld_err=0.
- Accepted ld_start at edge t: cpu_hold, ld_busy and ld_in_ready are all 1 from t+1.
- Write latency: im_wr_en is high in the cycle after the edge that accepts the 4th byte of a word.
- Back-to-back streaming (valid held high): one write every 4 cycles.
- Minimum load time: 2 + 4N byte cycles, plus 1 CSUM cycle, plus 1 DONE cycle.
- ld_done:
  - Without the macro: asserted in the cycle after the final im_wr_en.
  - With the macro: asserted in the cycle after CSUM acceptance.
  - Never overlaps im_wr_en.
- Accepted bytes never exceed 2 + 4N (+1 with the macro). ld_in_ready drops the cycle after the last byte is accepted.

## Configuration
- IM_LOADER_CSUM_EN defined:
  - Maintain a running XOR of all 4N payload bytes; length bytes are excluded.
  - CSUM state accepts one trailing byte.
  - Byte mismatches the running XOR: set ld_err, suppress ld_done, still pass through DONE, and release cpu_hold.
- IM_LOADER_CSUM_EN undefined:
  - No CSUM state and no XOR register.
  - The stream ends after the last payload byte.

## Test plan
- Stream N=2 (00 02), bytes 20 08 00 05 / 08 00 0C 00, base=0: writes {addr 0, 0x20080005} and {addr 1, 0x08000C00}; ld_done one cycle after the second write; cpu_hold high throughout, low after DONE.
- base=255, N=2, data AA..AA / BB..BB: writes addr 255 then addr 0 (wrap).
- Length 00 00, and separately 01 01: ld_err=1, no im_wr_en, return to IDLE, ld_done never pulses.
- Valid toggling every other cycle for N=1 word 0x12345678: a single write of 0x12345678; ld_start pulsed mid-load is ignored.
- rst_ld=0 after 2 of 4 DATA bytes: all outputs return to reset values next edge; a fresh load of N=1 writes its word correctly.
- With IM_LOADER_CSUM_EN, payload 01 02 03 04:
  - Checksum 04: ld_done=1, ld_err=0.
  - Checksum 05: ld_err=1, no ld_done, cpu_hold released.
